// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges ALU and load (MEM) writeback requests into a
// single registered register-file write port. Each requester owns a
// one-entry buffer; the older buffer wins the port, and equal-age ties go
// to MEM unless the REGARB_RR_EN macro is defined, in which case ties
// alternate between the two requesters (first tie after reset goes to MEM).
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     BUSYWAIT,
    input  logic                     ALU_REQ,
    input  logic [ADDR_W-1:0]        ALU_ADDR,
    input  logic [DATA_W-1:0]        ALU_DATA,
    output logic                     ALU_GNT,
    input  logic                     MEM_REQ,
    input  logic [ADDR_W-1:0]        MEM_ADDR,
    input  logic [DATA_W-1:0]        MEM_DATA,
    output logic                     MEM_GNT,
    output logic                     WRITE,
    output logic [ADDR_W-1:0]        INADDRESS,
    output logic [DATA_W-1:0]        IN,
    output logic [(1<<ADDR_W)-1:0]   PENDING
);

    localparam int NREG = 1 << ADDR_W;

    // Request buffers (stage p0). The age flag of a buffer is set when the
    // other buffer is accepted while this one is still held, i.e. this
    // entry is strictly older. Both flags clear means an equal-age tie.
    logic                alu_vld_p0, mem_vld_p0;
    logic [ADDR_W-1:0]   alu_addr_p0, mem_addr_p0;
    logic [DATA_W-1:0]   alu_data_p0, mem_data_p0;
    logic                alu_age_p0, mem_age_p0;

    logic alu_ld, mem_ld;
    logic adv;
    logic tie;
    logic tie_alu;
    logic sel_alu, sel_mem;
    logic alu_clr, mem_clr;
    logic alu_hold, mem_hold;

    assign ALU_GNT = !alu_vld_p0 && !RESET;
    assign MEM_GNT = !mem_vld_p0 && !RESET;

    assign alu_ld = ALU_REQ && ALU_GNT;
    assign mem_ld = MEM_REQ && MEM_GNT;

    // The output stage moves unless it holds a write the register file is
    // refusing this edge.
    assign adv = !(WRITE && BUSYWAIT);

    assign tie = alu_vld_p0 && mem_vld_p0 && !alu_age_p0 && !mem_age_p0;

`ifdef REGARB_RR_EN
    // High when the previous equal-age tie went to ALU; reset value makes
    // the first tie go to MEM.
    logic last_tie_alu;

    assign tie_alu = !last_tie_alu;

    // Remember which requester won the most recent tie.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_tie_alu <= 1'b1;
        end else if (adv && tie) begin
            last_tie_alu <= sel_alu;
        end
    end
`else
    assign tie_alu = 1'b0;
`endif

    assign sel_alu = alu_vld_p0 && (!mem_vld_p0 || alu_age_p0 || (tie && tie_alu));
    assign sel_mem = mem_vld_p0 && !sel_alu;

    assign alu_clr  = adv && sel_alu;
    assign mem_clr  = adv && sel_mem;
    assign alu_hold = alu_vld_p0 && !alu_clr;
    assign mem_hold = mem_vld_p0 && !mem_clr;

    // Buffer control: valid and relative-age bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_vld_p0 <= 1'b0;
            mem_vld_p0 <= 1'b0;
            alu_age_p0 <= 1'b0;
            mem_age_p0 <= 1'b0;
        end else begin
            if (alu_ld) begin
                alu_vld_p0 <= 1'b1;
            end else if (alu_clr) begin
                alu_vld_p0 <= 1'b0;
            end

            if (mem_ld) begin
                mem_vld_p0 <= 1'b1;
            end else if (mem_clr) begin
                mem_vld_p0 <= 1'b0;
            end

            if (alu_ld) begin
                alu_age_p0 <= 1'b0;
            end else if (mem_ld && alu_hold) begin
                alu_age_p0 <= 1'b1;
            end

            if (mem_ld) begin
                mem_age_p0 <= 1'b0;
            end else if (alu_ld && mem_hold) begin
                mem_age_p0 <= 1'b1;
            end
        end
    end

    // Buffer payload capture on handshake; contents are don't-care while invalid.
    always_ff @(posedge CLK) begin
        if (alu_ld) begin
            alu_addr_p0 <= ALU_ADDR;
            alu_data_p0 <= ALU_DATA;
        end
        if (mem_ld) begin
            mem_addr_p0 <= MEM_ADDR;
            mem_data_p0 <= MEM_DATA;
        end
    end

    // Output stage (p1): load the winning buffer, or drop WRITE when idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else if (adv) begin
            if (sel_alu) begin
                WRITE     <= 1'b1;
                INADDRESS <= alu_addr_p0;
                IN        <= alu_data_p0;
            end else if (sel_mem) begin
                WRITE     <= 1'b1;
                INADDRESS <= mem_addr_p0;
                IN        <= mem_data_p0;
            end else begin
                WRITE     <= 1'b0;
            end
        end
    end

    // Per-register flag of any held, uncommitted write.
    always_comb begin
        PENDING = '0;
        for (int i = 0; i < NREG; i++) begin
            PENDING[i] = (alu_vld_p0 && (alu_addr_p0 == ADDR_W'(i)))
                       || (mem_vld_p0 && (mem_addr_p0 == ADDR_W'(i)))
                       || (WRITE && (INADDRESS == ADDR_W'(i)));
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a timestamp-based model.
module tb_reg_write_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;
    localparam int NVEC   = 16;

    logic                CLK = 1'b0;
    logic                RESET, BUSYWAIT;
    logic                ALU_REQ, MEM_REQ;
    logic [ADDR_W-1:0]   ALU_ADDR, MEM_ADDR;
    logic [DATA_W-1:0]   ALU_DATA, MEM_DATA;
    logic                ALU_GNT, MEM_GNT, WRITE;
    logic [ADDR_W-1:0]   INADDRESS;
    logic [DATA_W-1:0]   IN;
    logic [NREG-1:0]     PENDING;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT),
        .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_GNT(ALU_GNT),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_GNT(MEM_GNT),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .PENDING(PENDING)
    );

    // Log of committed writes as {addr, data}
    logic [15:0] commits[$];
    always @(posedge CLK) begin
        if (WRITE && !BUSYWAIT && !RESET) commits.push_back({5'b0, INADDRESS, IN});
    end

    typedef struct {
        logic rst, busy, areq;
        logic [2:0] aaddr;
        logic [7:0] adata;
        logic mreq;
        logic [2:0] maddr;
        logic [7:0] mdata;
        logic agnt, mgnt, wr;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[NVEC];

    function automatic vec_t mk(input int rst, busy, areq, aa, ad, mreq, ma, md,
                                input int ag, mg, wr, wa, wd, pd);
        vec_t v;
        v.rst = 1'(rst);   v.busy = 1'(busy); v.areq = 1'(areq);
        v.aaddr = 3'(aa);  v.adata = 8'(ad);  v.mreq = 1'(mreq);
        v.maddr = 3'(ma);  v.mdata = 8'(md);
        v.agnt = 1'(ag);   v.mgnt = 1'(mg);   v.wr = 1'(wr);
        v.waddr = 3'(wa);  v.wdata = 8'(wd);  v.pend = 8'(pd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, busy, areq, input logic [2:0] aa, input logic [7:0] ad,
                         input logic mreq, input logic [2:0] ma, input logic [7:0] md);
        RESET = rst; BUSYWAIT = busy;
        ALU_REQ = areq; ALU_ADDR = aa; ALU_DATA = ad;
        MEM_REQ = mreq; MEM_ADDR = ma; MEM_DATA = md;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic busy, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, busy, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
            tick();
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
        tick();
        commits.delete();
    endtask

    // Reference model: buffers stamped with their acceptance cycle
    bit          mv[2];
    logic [2:0]  ma[2];
    logic [7:0]  md[2];
    int          ms[2];
    bit          mw;
    logic [2:0]  mwa;
    logic [7:0]  mwd;
    bit          lt_alu;
    int          cyc = 0;

    task automatic model_edge(input bit r, b, aq, input logic [2:0] aa, input logic [7:0] ad,
                              input bit mq, input logic [2:0] maa, input logic [7:0] mda);
        bit acc0, acc1;
        int w;
        if (r) begin
            mv[0] = 0; mv[1] = 0; mw = 0; mwa = '0; mwd = '0; lt_alu = 1;
        end else begin
            acc0 = aq && !mv[0];
            acc1 = mq && !mv[1];
            if (!(mw && b)) begin
                w = -1;
                if (mv[0] && mv[1]) begin
                    if (ms[0] < ms[1]) w = 0;
                    else if (ms[1] < ms[0]) w = 1;
                    else begin
`ifdef REGARB_RR_EN
                        w = lt_alu ? 1 : 0;
                        lt_alu = (w == 0);
`else
                        w = 1;
`endif
                    end
                end else if (mv[0]) w = 0;
                else if (mv[1]) w = 1;
                if (w >= 0) begin
                    mw = 1; mwa = ma[w]; mwd = md[w]; mv[w] = 0;
                end else begin
                    mw = 0;
                end
            end
            if (acc0) begin mv[0] = 1; ma[0] = aa;  md[0] = ad;  ms[0] = cyc; end
            if (acc1) begin mv[1] = 1; ma[1] = maa; md[1] = mda; ms[1] = cyc; end
        end
        cyc++;
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] p = '0;
        if (mv[0]) p[ma[0]] = 1'b1;
        if (mv[1]) p[ma[1]] = 1'b1;
        if (mw)    p[mwa]   = 1'b1;
        return p;
    endfunction

    initial begin
        bit r, b, aq, mq;
        logic [2:0] aa, maa;
        logic [7:0] ad, mda;

        //                rst bsy aq aa ad    mq ma md    ag mg wr wa wd    pend
        tbl[0]  = mk(1, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 'h00, 'h00);
        tbl[1]  = mk(0, 0, 1, 3, 'h5A, 0, 0, 0,    0, 1, 0, 0, 'h00, 'h08);
        tbl[2]  = mk(0, 0, 0, 0, 0,    0, 0, 0,    1, 1, 1, 3, 'h5A, 'h08);
        tbl[3]  = mk(0, 0, 0, 0, 0,    0, 0, 0,    1, 1, 0, 3, 'h5A, 'h00);
        tbl[4]  = mk(0, 0, 1, 2, 'h11, 1, 2, 'h22, 0, 0, 0, 3, 'h5A, 'h04);
        tbl[5]  = mk(0, 0, 0, 0, 0,    0, 0, 0,    0, 1, 1, 2, 'h22, 'h04);
        tbl[6]  = mk(0, 0, 0, 0, 0,    0, 0, 0,    1, 1, 1, 2, 'h11, 'h04);
        tbl[7]  = mk(0, 0, 0, 0, 0,    0, 0, 0,    1, 1, 0, 2, 'h11, 'h00);
        tbl[8]  = mk(0, 0, 1, 5, 'h77, 0, 0, 0,    0, 1, 0, 2, 'h11, 'h20);
        tbl[9]  = mk(0, 1, 0, 0, 0,    0, 0, 0,    1, 1, 1, 5, 'h77, 'h20);
        tbl[10] = mk(0, 1, 0, 0, 0,    1, 7, 'h02, 1, 0, 1, 5, 'h77, 'hA0);
        tbl[11] = mk(0, 1, 1, 6, 'h01, 0, 0, 0,    0, 0, 1, 5, 'h77, 'hE0);
        tbl[12] = mk(0, 1, 0, 0, 0,    0, 0, 0,    0, 0, 1, 5, 'h77, 'hE0);
        tbl[13] = mk(0, 0, 0, 0, 0,    0, 0, 0,    0, 1, 1, 7, 'h02, 'hC0);
        tbl[14] = mk(0, 0, 0, 0, 0,    0, 0, 0,    1, 1, 1, 6, 'h01, 'h40);
        tbl[15] = mk(0, 0, 0, 0, 0,    0, 0, 0,    1, 1, 0, 6, 'h01, 'h00);

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].busy, tbl[i].areq, tbl[i].aaddr, tbl[i].adata,
                  tbl[i].mreq, tbl[i].maddr, tbl[i].mdata);
            tick();
            chk($sformatf("vec%0d.alu_gnt", i), ALU_GNT, tbl[i].agnt);
            chk($sformatf("vec%0d.mem_gnt", i), MEM_GNT, tbl[i].mgnt);
            chk($sformatf("vec%0d.write", i), WRITE, tbl[i].wr);
            chk($sformatf("vec%0d.inaddress", i), INADDRESS, tbl[i].waddr);
            chk($sformatf("vec%0d.in", i), IN, tbl[i].wdata);
            chk($sformatf("vec%0d.pending", i), PENDING, tbl[i].pend);
        end

        // Older ALU entry beats younger MEM entry to the same register while stalled
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'd0); tick();
        idle(1'b0, 1);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 8'hA0, 1'b0, 3'd0, 8'd0); tick();
        drive(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 8'hB0); tick();
        chk("age.alu_gnt_full", ALU_GNT, 1'b0);
        chk("age.mem_gnt_full", MEM_GNT, 1'b0);
        chk("age.write_held", {WRITE, INADDRESS, IN}, {1'b1, 3'd4, 8'h44});
        idle(1'b1, 2);
        idle(1'b0, 4);
        chk("age.commit_count", commits.size(), 3);
        if (commits.size() == 3) begin
            chk("age.commit0", commits[0], {5'b0, 3'd4, 8'h44});
            chk("age.commit1", commits[1], {5'b0, 3'd1, 8'hA0});
            chk("age.commit2", commits[2], {5'b0, 3'd1, 8'hB0});
        end

        // Two successive equal-age pairs exercise the tie rule
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22); tick();
        idle(1'b0, 3);
        drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h33, 1'b1, 3'd2, 8'h44); tick();
        idle(1'b0, 3);
        chk("tie.commit_count", commits.size(), 4);
        if (commits.size() == 4) begin
            chk("tie.commit0", commits[0], {5'b0, 3'd2, 8'h22});
            chk("tie.commit1", commits[1], {5'b0, 3'd2, 8'h11});
`ifdef REGARB_RR_EN
            chk("tie.commit2", commits[2], {5'b0, 3'd2, 8'h33});
            chk("tie.commit3", commits[3], {5'b0, 3'd2, 8'h44});
`else
            chk("tie.commit2", commits[2], {5'b0, 3'd2, 8'h44});
            chk("tie.commit3", commits[3], {5'b0, 3'd2, 8'h33});
`endif
        end

        // Reset with both buffers and the output stage occupied
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h01, 1'b0, 3'd0, 8'd0); tick();
        idle(1'b0, 1);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 8'h02, 1'b1, 3'd3, 8'h03); tick();
        chk("rst.pre_pending", PENDING, 8'h0E);
        commits.delete();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0); tick();
        chk("rst.write", WRITE, 1'b0);
        chk("rst.pending", PENDING, 8'h00);
        chk("rst.gnts", {ALU_GNT, MEM_GNT}, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
        #1;
        chk("rst.gnts_release", {ALU_GNT, MEM_GNT}, 2'b11);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst.no_write%0d", k), WRITE, 1'b0);
        end
        chk("rst.no_commit", commits.size(), 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            r   = (n == 0) || ($urandom_range(0, 39) == 0);
            b   = ($urandom_range(0, 2) == 0);
            aq  = 1'($urandom_range(0, 1));
            mq  = 1'($urandom_range(0, 1));
            aa  = 3'($urandom_range(0, 7));
            maa = 3'($urandom_range(0, 7));
            ad  = 8'($urandom_range(0, 255));
            mda = 8'($urandom_range(0, 255));
            drive(r, b, aq, aa, ad, mq, maa, mda);
            @(negedge CLK);
            chk("rnd.alu_gnt", ALU_GNT, !mv[0] && !r);
            chk("rnd.mem_gnt", MEM_GNT, !mv[1] && !r);
            @(posedge CLK);
            model_edge(r, b, aq, aa, ad, mq, maa, mda);
            #1;
            chk("rnd.write", WRITE, mw);
            chk("rnd.inaddress", INADDRESS, mwa);
            chk("rnd.in", IN, mwd);
            chk("rnd.pending", PENDING, model_pending());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
